// File: rtl/prefix_reduce_pipe_if.sv
// prefix_reduce_pipe_if: handshake and data bundle for prefix_reduce_pipe.
// PREFIX_FIRST_ONE_EN adds first_vld/first_idx to the bundle.
interface prefix_reduce_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [1:0]       mode;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p;
    logic             total;
`ifdef PREFIX_FIRST_ONE_EN
    logic                     first_vld;
    logic [$clog2(WIDTH)-1:0] first_idx;
    modport master(output in_valid, a, mode, acc_en, acc_clr, out_ready,
                   input in_ready, out_valid, p, total, first_vld, first_idx);
    modport slave(input in_valid, a, mode, acc_en, acc_clr, out_ready,
                  output in_ready, out_valid, p, total, first_vld, first_idx);
`else
    modport master(output in_valid, a, mode, acc_en, acc_clr, out_ready,
                   input in_ready, out_valid, p, total);
    modport slave(input in_valid, a, mode, acc_en, acc_clr, out_ready,
                  output in_ready, out_valid, p, total);
`endif
endinterface

// File: rtl/prefix_reduce_pipe.sv
// prefix_reduce_pipe: registered OR/AND/XOR prefix reduction with valid/ready and cross-beat carry.
// Define PREFIX_FIRST_ONE_EN to add first_vld/first_idx (lowest set bit of p).
module prefix_reduce_pipe #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    prefix_reduce_pipe_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state, state_nxt;
    logic             accept, handoff, seed, r, carry_bit, carry_vld;
    logic [WIDTH-1:0] p_nxt, p_q;
    assign bus.in_ready  = state == EMPTY || bus.out_ready;
    assign bus.out_valid = state == FULL;
    assign bus.p         = p_q;
    assign bus.total     = p_q[WIDTH-1];
    assign accept        = bus.in_valid && bus.in_ready;
    assign handoff       = state == FULL && bus.out_ready;
    always_comb state_nxt = accept ? FULL : handoff ? EMPTY : state;
    always_ff @(posedge clk) state <= !rst_n ? EMPTY : state_nxt;
    // a concurrent acc_clr discards the stored carry before this beat's seed is chosen
    always_comb begin
        seed  = (bus.acc_en && carry_vld && !bus.acc_clr) ? carry_bit : bus.mode == 2'b01;
        r     = seed;
        p_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r = bus.mode == 2'b01 ? r & bus.a[i] : bus.mode == 2'b10 ? r ^ bus.a[i] : r | bus.a[i];
            p_nxt[i] = r;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q       <= '0;
            carry_bit <= 1'b0;
            carry_vld <= 1'b0;
        end else if (accept) begin
            p_q       <= p_nxt;
            carry_bit <= p_nxt[WIDTH-1];
            carry_vld <= 1'b1;
        end else if (bus.acc_clr) begin
            carry_vld <= 1'b0;
        end
    end
`ifdef PREFIX_FIRST_ONE_EN
    localparam int IW = $clog2(WIDTH);
    logic [IW-1:0] fi_nxt, fi_q;
    logic          fv_q;
    always_comb begin
        fi_nxt = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (p_nxt[i]) fi_nxt = IW'(i);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fv_q <= 1'b0;
            fi_q <= '0;
        end else if (accept) begin
            fv_q <= |p_nxt;
            fi_q <= fi_nxt;
        end
    end
    assign bus.first_vld = fv_q;
    assign bus.first_idx = fi_q;
`endif
endmodule

// File: tb/tb_prefix_reduce_pipe.sv
// tb_prefix_reduce_pipe: directed and random beats against a scoreboard of reference prefix results.
module tb_prefix_reduce_pipe;
    localparam int W = 4;
    typedef struct {
        logic [W-1:0] p;
        logic         fv;
        logic [1:0]   fi;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic m_full = 1'b0;
    logic m_bit = 1'b0;
    logic m_vld = 1'b0;

    prefix_reduce_pipe_if #(.WIDTH(W)) bus();
    prefix_reduce_pipe #(.WIDTH(W)) u_dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // each p[i] reduced independently over the masked prefix a[0..i]
    function automatic logic [W-1:0] ref_p(input logic [W-1:0] av, input logic [1:0] md, input logic sd);
        logic [W-1:0] res, m;
        res = '0;
        for (int i = 0; i < W; i++) begin
            m = W'((1 << (i + 1)) - 1);
            case (md)
                2'b01:   res[i] = sd & (&(av | ~m));
                2'b10:   res[i] = sd ^ (^(av & m));
                default: res[i] = sd | (|(av & m));
            endcase
        end
        return res;
    endfunction

    function automatic logic [1:0] low_idx(input logic [W-1:0] v);
        logic [1:0] k;
        k = '0;
        for (int i = W - 1; i >= 0; i--)
            if (v[i]) k = 2'(i);
        return k;
    endfunction

    task automatic cycle();
        logic acc, hs, sd;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            m_full = 1'b0;
            m_bit  = 1'b0;
            m_vld  = 1'b0;
        end else begin
            chk("out_valid", bus.out_valid, m_full);
            chk("in_ready", bus.in_ready, !m_full || bus.out_ready);
            hs  = m_full && bus.out_ready;
            acc = bus.in_valid && (!m_full || bus.out_ready);
            if (hs) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_p", bus.p, e.p);
                    chk("sb_total", bus.total, e.p[W-1]);
`ifdef PREFIX_FIRST_ONE_EN
                    chk("sb_first_vld", bus.first_vld, e.fv);
                    chk("sb_first_idx", bus.first_idx, e.fi);
`endif
                end
            end
            if (acc) begin
                sd   = (bus.acc_en && m_vld && !bus.acc_clr) ? m_bit : (bus.mode == 2'b01);
                e.p  = ref_p(bus.a, bus.mode, sd);
                e.fv = |e.p;
                e.fi = low_idx(e.p);
                sb.push_back(e);
                m_bit = e.p[W-1];
                m_vld = 1'b1;
            end else if (bus.acc_clr) begin
                m_vld = 1'b0;
            end
            m_full = acc ? 1'b1 : hs ? 1'b0 : m_full;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [W-1:0] av, input logic [1:0] md,
                        input logic ae, input logic ac);
        bus.in_valid = v;
        bus.a        = av;
        bus.mode     = md;
        bus.acc_en   = ae;
        bus.acc_clr  = ac;
    endtask

    initial begin
        beat(0, '0, 2'b00, 0, 0);
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_p", bus.p, 0);
        chk("rst_total", bus.total, 0);
        chk("rst_in_ready", bus.in_ready, 1);
`ifdef PREFIX_FIRST_ONE_EN
        chk("rst_first_vld", bus.first_vld, 0);
        chk("rst_first_idx", bus.first_idx, 0);
`endif
        beat(1, 4'b0100, 2'b00, 0, 0);
        cycle();
        chk("or_valid", bus.out_valid, 1);
        chk("or_p", bus.p, 4'b1100);
        chk("or_total", bus.total, 1);
`ifdef PREFIX_FIRST_ONE_EN
        chk("or_first_vld", bus.first_vld, 1);
        chk("or_first_idx", bus.first_idx, 2);
`endif
        beat(1, 4'b1011, 2'b01, 0, 0);
        cycle();
        chk("and_p", bus.p, 4'b0011);
        chk("and_total", bus.total, 0);
        beat(1, 4'b0110, 2'b10, 0, 0);
        cycle();
        chk("xor_valid", bus.out_valid, 1);
        chk("xor_p", bus.p, 4'b0010);
        beat(1, 4'b0001, 2'b00, 1, 0);
        cycle();
        chk("acc1_p", bus.p, 4'b1111);
        beat(1, 4'b0000, 2'b00, 1, 0);
        cycle();
        chk("acc2_p", bus.p, 4'b1111);
        beat(1, 4'b0000, 2'b00, 1, 1);
        cycle();
        chk("accclr_p", bus.p, 4'b0000);
        beat(0, '0, 2'b00, 0, 0);
        cycle();
        chk("drain_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        beat(1, 4'b1000, 2'b00, 0, 0);
        cycle();
        beat(1, 4'b0011, 2'b00, 0, 0);
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_p", bus.p, 4'b1000);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_second_p", bus.p, 4'b1111);
        beat(0, '0, 2'b00, 0, 0);
        cycle();
        bus.out_ready = 1'b0;
        beat(1, 4'b0000, 2'b10, 0, 0);
        cycle();
        beat(0, '0, 2'b00, 0, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_p", bus.p, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        beat(1, 4'b1111, 2'b01, 1, 0);
        cycle();
        chk("post_rst_p", bus.p, 4'b1111);
        beat(1, 4'b0010, 2'b11, 0, 0);
        cycle();
        chk("rsvd_p", bus.p, 4'b1110);
        for (int n = 0; n < 60; n++) begin
            beat(1'($urandom_range(0, 1)), W'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0);
            bus.out_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        beat(0, '0, 2'b00, 0, 0);
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
